regfile: RTL

General-purpose register file at the far end of the write-back interface. Consumes the MEM/WB write triple (destination address, data, write enable) on one port and serves two combinational read ports to the decode stage. Provides same-cycle write-to-read bypass and hardwires register 0 to zero. After reset, an internal sequencer clears every entry, one per cycle, and requests a pipeline stall until clearing is done, so the array can map onto RAM without a parallel reset.

---
 rtl/regfile.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile.sv
// Two-read, one-write general-purpose register file with write-to-read bypass.
// A post-reset sequencer zeroes the array one entry per cycle so it can map onto RAM.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy
);

    typedef enum logic {INIT, RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == INIT) begin
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d   = RUN;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Single write port shared by the clear sequencer and the write-back path;
    // the sequencer owns it for the whole of INIT, so pipeline writes there are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
        end else if (we && waddr != '0) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic re, input logic [ADDR_W-1:0] raddr);
        if (state_q == INIT || !re || raddr == '0) begin
            return '0;
        end else if (we && waddr == raddr) begin
            return wdata;
        end else begin
            return mem_q[raddr];
        end
    endfunction

    always_comb begin
        rdata1 = rd_port(re1, raddr1);
        rdata2 = rd_port(re2, raddr2);
    end

    assign init_busy = (state_q == INIT);

endmodule
